// File: rtl/snake_engine.sv
// Snake game core: body ring buffer, direction control, food handshake,
// wall/self collision and the frame bitmap for the display scanner.
module snake_engine #(
   parameter  int COLS    = 16,
   parameter  int ROWS    = 8,
   parameter  int MAX_LEN = 32,
   parameter  int WRAP    = 0,
   localparam int XW      = $clog2(COLS),
   localparam int YW      = $clog2(ROWS),
   localparam int LW      = $clog2(MAX_LEN + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tick,
   input  logic                 btnUp,
   input  logic                 btnDown,
   input  logic                 btnLeft,
   input  logic                 btnRight,
   input  logic                 start,
   input  logic [XW-1:0]        food_x,
   input  logic [YW-1:0]        food_y,
   input  logic                 food_valid,
   output logic                 food_req,
   output logic [ROWS*COLS-1:0] pixelReg,
   output logic [XW-1:0]        head_x,
   output logic [YW-1:0]        head_y,
   output logic [LW-1:0]        length,
   output logic                 running,
   output logic                 game_over,
   output logic                 won
);

   localparam int PIX = ROWS * COLS;
   localparam int IW  = $clog2(PIX);
   localparam int PW  = $clog2(MAX_LEN);

   typedef enum logic [1:0] {S_IDLE, S_FOOD, S_RUN, S_OVER} state_t;
   typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;
   typedef struct packed {
      logic [XW-1:0] x;
      logic [YW-1:0] y;
   } cell_t;

   function automatic logic [IW-1:0] cell_idx(cell_t c);
      return IW'(int'(c.y) * COLS + int'(c.x));
   endfunction

   function automatic cell_t reset_cell(int i);
      cell_t c;
      c = '0;
      if (i < 3) c.x = XW'(i);
      return c;
   endfunction

   function automatic logic [PW-1:0] ptr_inc(logic [PW-1:0] p);
      return (p == PW'(MAX_LEN - 1)) ? '0 : p + 1'b1;
   endfunction

   // Encoding puts each opposite pair in the same half: differ only in bit 0.
   function automatic logic is_opposite(dir_t a, dir_t b);
      return (a[1] == b[1]) && (a[0] != b[0]);
   endfunction

   state_t          state_q, state_d;
   dir_t            next_dir_q, next_dir_d;
   dir_t            last_dir_q, last_dir_d;
   cell_t           body_q [MAX_LEN];
   cell_t           body_d [MAX_LEN];
   cell_t           head_q, head_d;
   cell_t           food_q, food_d;
   logic            food_vld_q, food_vld_d;
   logic [PW-1:0]   head_ptr_q, head_ptr_d;
   logic [PW-1:0]   tail_ptr_q, tail_ptr_d;
   logic [LW-1:0]   length_q, length_d;
   logic [PIX-1:0]  occ_q, occ_d;
   logic            won_q, won_d;

   cell_t           nxt, tail_cell, offer;
   dir_t            btn_dir, exec_dir;
   logic            btn_vld, oob, grow, hit, offer_ok;
   logic [IW-1:0]   nxt_idx;

   always_comb begin
      // NOTE: every signal gets a default before any branch, so no latch is inferred.
      state_d    = state_q;
      next_dir_d = next_dir_q;
      last_dir_d = last_dir_q;
      body_d     = body_q;
      head_d     = head_q;
      food_d     = food_q;
      food_vld_d = food_vld_q;
      head_ptr_d = head_ptr_q;
      tail_ptr_d = tail_ptr_q;
      length_d   = length_q;
      occ_d      = occ_q;
      won_d      = won_q;

      btn_vld = btnUp | btnDown | btnLeft | btnRight;
      if (btnUp)         btn_dir = D_UP;
      else if (btnDown)  btn_dir = D_DOWN;
      else if (btnLeft)  btn_dir = D_LEFT;
      else               btn_dir = D_RIGHT;
      // A press during a tick is judged against the move being executed now.
      exec_dir = tick ? next_dir_q : last_dir_q;

      nxt = head_q;
      oob = 1'b0;
      case (next_dir_q)
         D_UP: begin
            if (head_q.y == '0) begin oob = 1'b1; nxt.y = YW'(ROWS - 1); end
            else nxt.y = head_q.y - 1'b1;
         end
         D_DOWN: begin
            if (head_q.y == YW'(ROWS - 1)) begin oob = 1'b1; nxt.y = '0; end
            else nxt.y = head_q.y + 1'b1;
         end
         D_LEFT: begin
            if (head_q.x == '0) begin oob = 1'b1; nxt.x = XW'(COLS - 1); end
            else nxt.x = head_q.x - 1'b1;
         end
         default: begin
            if (head_q.x == XW'(COLS - 1)) begin oob = 1'b1; nxt.x = '0; end
            else nxt.x = head_q.x + 1'b1;
         end
      endcase

      nxt_idx   = cell_idx(nxt);
      tail_cell = body_q[tail_ptr_q];
      grow      = food_vld_q && (nxt == food_q);
      hit       = occ_q[nxt_idx] && !(!grow && (nxt == tail_cell));

      offer.x  = food_x;
      offer.y  = food_y;
      offer_ok = food_valid && (int'(food_x) < COLS) && (int'(food_y) < ROWS)
                 && !occ_q[cell_idx(offer)];

      case (state_q)
         S_IDLE: if (start) state_d = S_FOOD;
         S_FOOD: begin
            if (offer_ok) begin
               food_d     = offer;
               food_vld_d = 1'b1;
               state_d    = S_RUN;
            end
         end
         S_RUN: begin
            if (btn_vld && !is_opposite(btn_dir, exec_dir)) next_dir_d = btn_dir;
            if (tick) begin
               last_dir_d = next_dir_q;
               if ((oob && WRAP == 0) || hit) begin
                  state_d = S_OVER;
               end else begin
                  // Tail is cleared before the head is set so chasing the tail keeps its bit.
                  if (!grow) begin
                     occ_d[cell_idx(tail_cell)] = 1'b0;
                     tail_ptr_d = ptr_inc(tail_ptr_q);
                  end
                  occ_d[nxt_idx]          = 1'b1;
                  head_ptr_d              = ptr_inc(head_ptr_q);
                  body_d[ptr_inc(head_ptr_q)] = nxt;
                  head_d                  = nxt;
                  if (grow) begin
                     length_d   = length_q + 1'b1;
                     food_vld_d = 1'b0;
                     if (length_q + 1'b1 == LW'(MAX_LEN)) begin
                        won_d   = 1'b1;
                        state_d = S_OVER;
                     end else begin
                        state_d = S_FOOD;
                     end
                  end
               end
            end
         end
         default: begin
            if (start) begin
               state_d    = S_IDLE;
               next_dir_d = D_RIGHT;
               last_dir_d = D_RIGHT;
               for (int i = 0; i < 3; i++) body_d[i] = reset_cell(i);
               head_d     = reset_cell(2);
               food_d     = '0;
               food_vld_d = 1'b0;
               head_ptr_d = PW'(2);
               tail_ptr_d = '0;
               length_d   = LW'(3);
               occ_d      = PIX'(7);
               won_d      = 1'b0;
            end
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; blocking stays in always_comb.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         next_dir_q <= D_RIGHT;
         last_dir_q <= D_RIGHT;
         head_q     <= reset_cell(2);
         food_q     <= '0;
         food_vld_q <= 1'b0;
         head_ptr_q <= PW'(2);
         tail_ptr_q <= '0;
         length_q   <= LW'(3);
         occ_q      <= PIX'(7);
         won_q      <= 1'b0;
         // NOTE: the body buffer is reset too, since the reset layout must be readable at once.
         for (int i = 0; i < MAX_LEN; i++) body_q[i] <= reset_cell(i);
      end else begin
         state_q    <= state_d;
         next_dir_q <= next_dir_d;
         last_dir_q <= last_dir_d;
         head_q     <= head_d;
         food_q     <= food_d;
         food_vld_q <= food_vld_d;
         head_ptr_q <= head_ptr_d;
         tail_ptr_q <= tail_ptr_d;
         length_q   <= length_d;
         occ_q      <= occ_d;
         won_q      <= won_d;
         for (int i = 0; i < MAX_LEN; i++) body_q[i] <= body_d[i];
      end
   end

   assign pixelReg  = occ_q | (PIX'(food_vld_q) << cell_idx(food_q));
   assign head_x    = head_q.x;
   assign head_y    = head_q.y;
   assign length    = length_q;
   assign food_req  = (state_q == S_FOOD);
   assign running   = (state_q == S_RUN);
   assign game_over = (state_q == S_OVER);
   assign won       = won_q;

endmodule

// File: tb/tb_snake_engine.sv
// Directed bench for snake_engine: one wall-mode and one wrap-mode instance
// driven by the same stimulus, checked against hand-computed values.
module tb_snake_engine;

   logic         clk = 1'b0;
   logic         reset, tick, btn_up, btn_down, btn_left, btn_right, start, food_valid;
   logic [3:0]   food_x;
   logic [2:0]   food_y;

   logic         food_req0, run0, over0, won0;
   logic [127:0] pix0;
   logic [3:0]   hx0;
   logic [2:0]   hy0;
   logic [5:0]   len0;

   logic         food_req1, run1, over1, won1;
   logic [127:0] pix1;
   logic [3:0]   hx1;
   logic [2:0]   hy1;
   logic [5:0]   len1;

   int passed = 0;
   int total  = 0;
   logic [127:0] e;

   always #5 clk = ~clk;

   snake_engine #(.COLS(16), .ROWS(8), .MAX_LEN(32), .WRAP(0)) dut_wall (
      .clk(clk), .reset(reset), .tick(tick),
      .btnUp(btn_up), .btnDown(btn_down), .btnLeft(btn_left), .btnRight(btn_right),
      .start(start), .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
      .food_req(food_req0), .pixelReg(pix0), .head_x(hx0), .head_y(hy0),
      .length(len0), .running(run0), .game_over(over0), .won(won0)
   );

   snake_engine #(.COLS(16), .ROWS(8), .MAX_LEN(32), .WRAP(1)) dut_wrap (
      .clk(clk), .reset(reset), .tick(tick),
      .btnUp(btn_up), .btnDown(btn_down), .btnLeft(btn_left), .btnRight(btn_right),
      .start(start), .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
      .food_req(food_req1), .pixelReg(pix1), .head_x(hx1), .head_y(hy1),
      .length(len1), .running(run1), .game_over(over1), .won(won1)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_tick();
      tick = 1'b1;
      step();
      tick = 1'b0;
   endtask

   task automatic offer(input logic [3:0] x, input logic [2:0] y);
      food_x = x;
      food_y = y;
      food_valid = 1'b1;
      step();
      food_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // 0=up 1=down 2=left 3=right: press for one cycle, then tick.
   task automatic move(input int d);
      btn_up    = (d == 0);
      btn_down  = (d == 1);
      btn_left  = (d == 2);
      btn_right = (d == 3);
      step();
      {btn_up, btn_down, btn_left, btn_right} = 4'b0;
      do_tick();
   endtask

   initial begin
      reset = 1'b1;
      {tick, btn_up, btn_down, btn_left, btn_right, start, food_valid} = '0;
      food_x = '0;
      food_y = '0;
      step();
      step();
      check("rst_pix",  pix0, 128'h7);
      check("rst_hx",   128'(hx0), 128'd2);
      check("rst_hy",   128'(hy0), 128'd0);
      check("rst_len",  128'(len0), 128'd3);
      check("rst_freq", 128'(food_req0), 128'd0);
      check("rst_run",  128'(run0), 128'd0);
      check("rst_over", 128'(over0), 128'd0);
      check("rst_won",  128'(won0), 128'd0);
      reset = 1'b0;
      step();

      pulse_start();
      check("idle_to_food_req", 128'(food_req0), 128'd1);
      offer(4'd1, 3'd0);
      check("occupied_offer_req", 128'(food_req0), 128'd1);
      check("occupied_offer_pix", pix0, 128'h7);
      offer(4'd5, 3'd0);
      check("accept_run",  128'(run0), 128'd1);
      check("accept_pix",  pix0, 128'h27);
      check("accept_freq", 128'(food_req0), 128'd0);

      do_tick();
      check("tick1_hx",  128'(hx0), 128'd3);
      check("tick1_pix", pix0, 128'h2E);
      do_tick();
      check("tick2_pix", pix0, 128'h3C);
      do_tick();
      check("eat_hx",   128'(hx0), 128'd5);
      check("eat_len",  128'(len0), 128'd4);
      check("eat_pix",  pix0, 128'h3C);
      check("eat_freq", 128'(food_req0), 128'd1);
      check("eat_run",  128'(run0), 128'd0);

      offer(4'd10, 3'd3);
      e = 128'h3C | (128'd1 << 58);
      check("food2_pix", pix0, e);
      pulse_start();
      check("start_in_run_ignored", 128'(run0), 128'd1);

      move(2);
      check("reverse_ignored_hx", 128'(hx0), 128'd6);
      check("reverse_ignored_hy", 128'(hy0), 128'd0);
      e = 128'h78 | (128'd1 << 58);
      check("reverse_ignored_pix", pix0, e);
      move(1);
      check("down_hx", 128'(hx0), 128'd6);
      check("down_hy", 128'(hy0), 128'd1);

      btn_right = 1'b1;
      tick = 1'b1;
      step();
      btn_right = 1'b0;
      tick = 1'b0;
      check("btn_with_tick_hx", 128'(hx0), 128'd6);
      check("btn_with_tick_hy", 128'(hy0), 128'd2);
      do_tick();
      check("btn_next_tick_hx", 128'(hx0), 128'd7);
      check("btn_next_tick_hy", 128'(hy0), 128'd2);

      move(0);
      do_tick();
      check("at_top_hy",  128'(hy0), 128'd0);
      check("at_top_run", 128'(run0), 128'd1);
      do_tick();
      check("wall_over",  128'(over0), 128'd1);
      check("wall_run",   128'(run0), 128'd0);
      check("wall_won",   128'(won0), 128'd0);
      check("wall_hy",    128'(hy0), 128'd0);
      check("wall_len",   128'(len0), 128'd4);
      e = (128'd1 << 38) | (128'd1 << 39) | (128'd1 << 23) | (128'd1 << 7) | (128'd1 << 58);
      check("wall_pix",   pix0, e);
      check("wrap_hy",    128'(hy1), 128'd7);
      check("wrap_hx",    128'(hx1), 128'd7);
      check("wrap_run",   128'(run1), 128'd1);
      e = (128'd1 << 39) | (128'd1 << 23) | (128'd1 << 7) | (128'd1 << 119) | (128'd1 << 58);
      check("wrap_pix",   pix1, e);

      move(2);
      do_tick();
      e = (128'd1 << 38) | (128'd1 << 39) | (128'd1 << 23) | (128'd1 << 7) | (128'd1 << 58);
      check("frozen_pix",  pix0, e);
      check("frozen_hx",   128'(hx0), 128'd7);
      check("frozen_over", 128'(over0), 128'd1);
      check("wrap_moving_hx", 128'(hx1), 128'd5);

      pulse_start();
      check("restart_pix",  pix0, 128'h7);
      check("restart_over", 128'(over0), 128'd0);
      check("restart_len",  128'(len0), 128'd3);
      check("restart_idle", 128'(run0), 128'd0);
      check("wrap_start_ignored", 128'(run1), 128'd1);

      reset = 1'b1;
      #1;
      check("async_rst_pix", pix1, 128'h7);
      check("async_rst_hx",  128'(hx1), 128'd2);
      check("async_rst_run", 128'(run1), 128'd0);
      check("async_rst_len", 128'(len1), 128'd3);
      step();
      reset = 1'b0;
      step();

      pulse_start();
      offer(4'd3, 3'd0);
      do_tick();
      check("loop_grow_len", 128'(len0), 128'd4);
      check("loop_grow_hx",  128'(hx0), 128'd3);
      offer(4'd15, 3'd7);
      move(1);
      move(2);
      move(0);
      check("tail_chase_ok", 128'(over0), 128'd0);
      move(3);
      move(1);
      move(2);
      move(0);
      e = (128'd1 << 2) | (128'd1 << 3) | (128'd1 << 18) | (128'd1 << 19) | (128'd1 << 127);
      check("loop_pix",  pix0, e);
      check("loop_run",  128'(run0), 128'd1);
      check("loop_over", 128'(over0), 128'd0);
      check("loop_len",  128'(len0), 128'd4);
      check("loop_hx",   128'(hx0), 128'd2);
      check("loop_hy",   128'(hy0), 128'd0);
      check("loop_wrap_over", 128'(over1), 128'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/snake_engine.md
Name: snake_engine

Overview:
- Parametrised snake game core: owns the body position queue, direction control, food handshake, collision detection and the frame bitmap.
- Generalises the fixed 8x16 controller to any grid size, maximum length and edge mode (wall or wrap).
- Adds self/wall collision, game-over and win states, and restart.
- Sits between the button/tick sources and the display scanner. Food coordinates come from an external randomizer through a req/valid handshake.

Parameters:
COLS, 16, grid width (>=4)
ROWS, 8, grid height (>=2)
MAX_LEN, 32, maximum body length (4..ROWS*COLS)
WRAP, 0, 0 = edge kills, 1 = edges wrap around
Derived: XW=$clog2(COLS), YW=$clog2(ROWS), LW=$clog2(MAX_LEN+1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
tick  in  1  one-cycle step strobe
btnUp  in  1  direction request up (y-1)
btnDown  in  1  direction request down (y+1)
btnLeft  in  1  direction request left (x-1)
btnRight  in  1  direction request right (x+1)
start  in  1  start / restart request
food_x  in  XW  offered food column
food_y  in  YW  offered food row
food_valid  in  1  food offer valid
food_req  out  1  engine needs a food position
pixelReg  out  ROWS*COLS  bitmap; bit y*COLS+x is set when the cell holds body or food
head_x  out  XW  head column
head_y  out  YW  head row
length  out  LW  current body length
running  out  1  high in RUN
game_over  out  1  high in OVER
won  out  1  high in OVER when MAX_LEN was reached

Behaviour:
- Reset and restart configuration:
  - Body at (0,0),(1,0),(2,0); head (2,0); direction right; length=3; state IDLE.
  - Outputs: pixelReg bits 0..2 set, all other bits 0; food_req=0, running=0, game_over=0, won=0.
- Body storage:
  - Circular buffer of MAX_LEN {x,y} entries with head_ptr and tail_ptr, both wrapping modulo MAX_LEN.
  - Occupancy bitmap is updated in the same cycle as the pointers.
- IDLE: start=1 -> FOOD.
- FOOD:
  - food_req=1 every cycle in FOOD.
  - food_valid with coordinate in range and cell unoccupied: accept, store food, set its pixel, go to RUN next cycle.
  - Any other offer is rejected and food_req stays 1.
  - tick is ignored in FOOD (snake paused).
- RUN, direction control:
  - A button press updates next_dir. Priority when several are pressed: up > down > left > right.
  - A request opposite to last_dir (the direction of the last executed move) is ignored.
  - A button in the same cycle as tick affects the following tick, not this one.
- RUN, on tick:
  - Compute next head from next_dir; next_dir becomes last_dir.
  - Out of range: WRAP=0 -> OVER. WRAP=1 -> coordinate wraps (x=-1 -> COLS-1, x=COLS -> 0, same for y).
  - Self collision: next cell occupied -> OVER. Exception: the current tail cell is legal when not growing, because the tail vacates in the same step.
  - next head == food: push head, keep tail, length+1, clear food.
    - If length is now MAX_LEN -> OVER with won=1.
    - Otherwise -> FOOD.
  - Otherwise: push head, pop tail (clear its bit), length unchanged.
  - All results, including game_over, are visible one cycle after the tick edge.
- OVER:
  - pixelReg, head, length and won are frozen; tick and buttons are ignored.
  - start -> reload the reset configuration and enter IDLE next cycle.
- start while in FOOD or RUN is ignored.
- Asynchronous reset at any time, including mid-step or mid-handshake, forces the reset configuration immediately and aborts any pending food offer.

Test Plan:
- Reset -> pixelReg==0x7, head=(2,0), length=3, food_req=0, running=0.
- Start, offer (1,0) -> rejected, food_req stays 1. Offer (5,0) -> accepted; pixelReg bit 5 set; running=1 next cycle.
- Three ticks with no button -> after the third tick head=(5,0), length=4, bits 2..5 set, food_req=1.
- While moving right, pulse btnLeft then tick -> head x+1 (reversal ignored). Pulse btnDown then tick -> head y+1.
- WRAP=0, press btnUp at y=0 and tick -> game_over=1, running=0; further ticks change nothing. WRAP=1, same stimulus -> head_y=ROWS-1.
- Length 4 snake in a 2x2 loop chasing its own tail -> no game_over. Assert reset mid-RUN -> reset values visible before the next clk edge.
